// File: rtl/register_19bit_pkg.sv
// Shared CPU datapath constants and the register command decode.
package register_19bit_pkg;

    localparam int unsigned REG_WIDTH = 19;

    localparam logic [REG_WIDTH-1:0] REG_ZERO = '0;
    localparam logic [REG_WIDTH-1:0] REG_ONE  = {{(REG_WIDTH-1){1'b0}}, 1'b1};

    // Per-edge command, highest priority first: clear, load, increment, hold.
    typedef enum logic [1:0] {
        CMD_HOLD = 2'd0,
        CMD_INC  = 2'd1,
        CMD_LOAD = 2'd2,
        CMD_CLR  = 2'd3
    } reg_cmd_e;

    function automatic reg_cmd_e decode_cmd(input logic clr, input logic load, input logic inc);
        if (clr)
            return CMD_CLR;
        else if (load)
            return CMD_LOAD;
        else if (inc)
            return CMD_INC;
        else
            return CMD_HOLD;
    endfunction

endpackage

// File: rtl/register_19bit_if.sv
// Load/increment bus for the datapath registers.
interface register_19bit_if
    import register_19bit_pkg::*;
#(
    parameter int unsigned WIDTH = REG_WIDTH
);

    logic [WIDTH-1:0] inpData;
    logic             LOAD;
    logic             INC;
    logic [WIDTH-1:0] opData;

    modport master (
        output inpData,
        output LOAD,
        output INC,
        input  opData
    );

    modport slave (
        input  inpData,
        input  LOAD,
        input  INC,
        output opData
    );

endinterface

// File: rtl/register_19bit_incrementer_19.sv
// Combinational WIDTH-bit +1 with silent wrap; shared by the PC/AR registers.
module incrementer_19
    import register_19bit_pkg::*;
#(
    parameter int unsigned WIDTH = REG_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] y
);

    localparam logic [WIDTH-1:0] ONE_W = {{(WIDTH-1){1'b0}}, 1'b1};

    // Carry out of the top bit is discarded, giving mod 2^WIDTH behaviour.
    always_comb begin
        y = a + ONE_W;
    end

endmodule

// File: rtl/register_19bit.sv
// WIDTH-bit datapath register with clear > load > increment > hold priority.
module register_19bit
    import register_19bit_pkg::*;
#(
    parameter int unsigned WIDTH = REG_WIDTH
) (
    input  logic            CLK,
    input  logic            CLR,
    register_19bit_if.slave bus
);

    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] q_inc;

    incrementer_19 #(.WIDTH(WIDTH)) u_inc (
        .a (q),
        .y (q_inc)
    );

    // Single owner of the register; CLR is a synchronous clear.
    always_ff @(posedge CLK) begin
        case (decode_cmd(CLR, bus.LOAD, bus.INC))
            CMD_CLR:  q <= '0;
            CMD_LOAD: q <= bus.inpData;
            CMD_INC:  q <= q_inc;
            default:  q <= q;
        endcase
    end

    assign bus.opData = q;

endmodule

// File: tb/tb_register_19bit.sv
// Self-checking bench: directed cases plus randomized commands vs. an arithmetic model.
module tb_register_19bit;

    localparam int unsigned W   = 19;
    localparam int unsigned MOD = 1 << W;

    logic CLK;
    logic CLR;

    register_19bit_if #(.WIDTH(W)) bif ();

    register_19bit #(.WIDTH(W)) dut (
        .CLK (CLK),
        .CLR (CLR),
        .bus (bif)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int unsigned n_cmp  = 0;
    int unsigned n_fail = 0;
    int unsigned model  = 0;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%05h expected 0x%05h", tag, got, exp);
        end
    endtask

    // Drive controls at the falling edge, apply one rising edge, update the model, check 1 ns later.
    task automatic step(input logic clr, input logic load, input logic inc,
                        input logic [W-1:0] data, input string tag);
        @(negedge CLK);
        CLR         = clr;
        bif.LOAD    = load;
        bif.INC     = inc;
        bif.inpData = data;
        @(posedge CLK);
        if (clr)
            model = 0;
        else if (load)
            model = int'(data);
        else if (inc)
            model = (model + 1) % MOD;
        #1;
        check(tag, bif.opData, W'(model));
    endtask

    initial begin
        CLR         = 1'b0;
        bif.LOAD    = 1'b0;
        bif.INC     = 1'b0;
        bif.inpData = '0;

        // Clear wins over a simultaneous load.
        step(1'b1, 1'b1, 1'b0, 19'h12345, "clear_with_load");

        // Load then hold for three edges.
        step(1'b0, 1'b1, 1'b0, 19'h5A5A5, "load");
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b0, 1'b0, 19'h00000, "hold");

        // Load 5 then three increments.
        step(1'b0, 1'b1, 1'b0, 19'h00005, "load5");
        step(1'b0, 1'b0, 1'b1, 19'h00000, "inc6");
        step(1'b0, 1'b0, 1'b1, 19'h00000, "inc7");
        step(1'b0, 1'b0, 1'b1, 19'h00000, "inc8");
        check("inc_abs", bif.opData, 19'h00008);

        // Wrap from all-ones to zero.
        step(1'b0, 1'b1, 1'b0, 19'h7FFFF, "load_max");
        step(1'b0, 1'b0, 1'b1, 19'h00000, "wrap");
        check("wrap_abs", bif.opData, 19'h00000);

        // Load beats increment; clear beats increment.
        step(1'b0, 1'b1, 1'b1, 19'h00100, "load_over_inc");
        check("load_over_inc_abs", bif.opData, 19'h00100);
        step(1'b1, 1'b0, 1'b1, 19'h00000, "clr_over_inc");

        // Release of clear lets the next edge load normally.
        step(1'b0, 1'b1, 1'b0, 19'h2AAAA, "after_clr_load");

        // No same-cycle bypass: inputs driven before the edge must not show yet.
        @(negedge CLK);
        bif.LOAD    = 1'b1;
        bif.inpData = 19'h11111;
        #2;
        check("no_bypass", bif.opData, W'(model));
        @(posedge CLK);
        model = 32'h11111;
        #1;
        check("load_after_edge", bif.opData, 19'h11111);

        // Mid-cycle glitch on LOAD/inpData with no edge while high.
        bif.LOAD    = 1'b0;
        #1;
        bif.inpData = 19'h3C3C3;
        bif.LOAD    = 1'b1;
        #2;
        bif.LOAD    = 1'b0;
        bif.inpData = 19'h00000;
        check("glitch_mid", bif.opData, 19'h11111);
        step(1'b0, 1'b0, 1'b0, 19'h00000, "glitch_edge");

        // Randomized commands, with occasional near-max loads to exercise wrap.
        for (int i = 0; i < 400; i++) begin
            logic [W-1:0] d;
            logic c, l, n;
            d = W'($urandom);
            if ($urandom_range(0, 7) == 0)
                d = 19'h7FFFF - W'($urandom_range(0, 2));
            c = ($urandom_range(0, 15) == 0);
            l = ($urandom_range(0, 3) == 0);
            n = ($urandom_range(0, 1) == 1);
            step(c, l, n, d, "random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
